uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte FIFO and handshake stage directly upstream of the UART transmitter. Capture/readout logic
//  pushes bytes at system-clock rate. The feeder pops them one at a time and presents each on
//  data_out/trans_en. It paces each hand-off to the transmitter's baud-tick sampling and tx_busy.
//  No byte is dropped or duplicated once accepted into the FIFO.
// PARAMETERS
//  DEPTH        16     FIFO entries, power of 2, >=2
//  HOLD_CYCLES  10416  clocks trans_en/data_out held stable; must be >= one full baud_clock period
//  SYNC_STAGES  2      flops synchronising tx_busy (>=2)
// PORTS
//  input_clk  in   1                system clock; sole clock
//  reset      in   1                asynchronous, active-high reset
//  flush      in   1                sync; empties FIFO, aborts pending hand-off
//  wr_en      in   1                push wr_data when !full
//  wr_data    in   8                byte to send
//  full       out  1                count==DEPTH
//  empty      out  1                count==0
//  count      out  $clog2(DEPTH)+1  bytes currently stored
//  overflow   out  1                sticky: push attempted while full; cleared by reset/flush
//  trans_en   out  1                request to transmitter
//  data_out   out  8                byte to transmitter, registered
//  tx_busy    in   1                transmitter busy; asynchronous to feeder timing, synchronised
// BEHAVIOUR
//  Reset (async):
//   - trans_en=0, data_out=8'h00, count=0, empty=1, full=0, overflow=0.
//   - Pointers=0, state=IDLE, hold counter=0, sync flops=0.
//  FIFO:
//   - Circular buffer; pointers wrap DEPTH-1 -> 0.
//   - Push and pop in the same cycle: count unchanged.
//   - Push while full: data ignored, overflow<=1, even if a pop occurs that cycle.
//   - Pop only when !empty; no write-to-read bypass.
//  Downstream contract:
//   - Transmitter latches data_out on its own baud tick while idle with trans_en=1.
//   - Its tx_busy mirrors trans_en combinationally while idle, so tx_busy rising is NOT an acceptance.
//   - Acceptance is guaranteed only by holding the request for HOLD_CYCLES.
//   - Completion is tx_busy_s==0 after trans_en has been released.
//  FSM (feeder_state_t):
//   - IDLE : if !empty && tx_busy_s==0 -> LOAD.
//   - LOAD : data_out<=mem[rd_ptr]; rd_ptr++, count-- (one cycle) -> HOLD; hold_cnt<=HOLD_CYCLES-1.
//   - HOLD : trans_en=1, data_out frozen; hold_cnt-- each clk; at 0 -> DRAIN.
//   - DRAIN: trans_en=0; wait tx_busy_s==0 -> IDLE. data_out keeps last byte.
//  Timing:
//   - trans_en is registered: high on the first HOLD cycle, for exactly HOLD_CYCLES cycles.
//   - Latency wr_en -> trans_en rise, with the FIFO empty and the transmitter idle: 3 clocks
//     (write, IDLE->LOAD, LOAD->HOLD).
//   - trans_en never rises while tx_busy_s==1; consecutive requests separated by >=1 low cycle.
//   - Pushes are accepted in every state.
//  Flush:
//   - Next cycle: pointers/count=0, overflow=0, state=IDLE, trans_en=0.
//   - A frame already started by the transmitter completes; IDLE waits on tx_busy_s before the next byte.
//   - Flush with a simultaneous push: flush wins, byte dropped, overflow stays 0.
// STRUCTURE
//  - Package uart_pkg: typedef enum logic[1:0] feeder_state_t {IDLE,LOAD,HOLD,DRAIN};
//    typedef logic[7:0] uart_byte_t; localparam UART_BAUD_DIV=5208;
//    localparam UART_HOLD_CYCLES=2*UART_BAUD_DIV.
//  - Sub-module byte_fifo: storage, pointers, count, full/empty/overflow, flush.
//  - Top: sync chain, hold counter, FSM.
// TESTING (HOLD_CYCLES=8; behavioural transmitter model: tick every 4 clks, 10-tick frame)
//  1 Reset asserted mid-run -> trans_en=0, data_out=00, count=0, empty=1, overflow=0 immediately,
//    without waiting for a clock edge.
//  2 Push 8'hA5 into empty FIFO -> trans_en rises 3 clks later, high exactly 8 clks,
//    data_out=A5 throughout; model receives A5.
//  3 Burst push 01,02,03 -> model receives 01,02,03 in order; trans_en low whenever tx_busy_s=1;
//    count 3->0.
//  4 Push 17 bytes (00..10) with model stalled busy -> full=1 after 16th push; overflow=1;
//    byte 10 lost; 00..0F delivered after release.
//  5 Assert reset during HOLD with 4 bytes queued -> trans_en=0 asynchronously;
//    after release no byte is emitted.
//  6 flush during DRAIN with 5 bytes queued, then push 3C -> in-flight frame finishes;
//    next delivered byte is 3C; overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD, DRAIN} feeder_state_t;

    typedef logic [7:0] uart_byte_t;

    localparam int unsigned UART_BAUD_DIV    = 5208;
    // Hold a request for two baud periods so at least one full baud tick falls inside it.
    localparam int unsigned UART_HOLD_CYCLES = 2 * UART_BAUD_DIV;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with sticky overflow flag and synchronous flush.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     input_clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    uart_byte_t        mem [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic              overflow_q;
    logic              push;
    logic              pop;

    // Full is judged before any same-cycle pop, so a push while full is always rejected.
    assign push = wr_en && !full && !flush;
    assign pop  = rd_en && !empty && !flush;

    // Pointer, occupancy and overflow state; flush wins over everything else.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage array, left unreset so it can map onto RAM.
    always_ff @(posedge input_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// Pops bytes from the FIFO and hands each to the UART transmitter with a timed request.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HOLD_CYCLES = UART_HOLD_CYCLES,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     input_clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     trans_en,
    output logic [7:0]               data_out,
    input  logic                     tx_busy
);

    localparam int unsigned HoldW    = $clog2(HOLD_CYCLES);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   tx_busy_s;

    feeder_state_t          state_q, state_d;
    logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
    logic                   trans_en_q, trans_en_d;
    uart_byte_t             data_out_q, data_out_d;

    logic                   fifo_pop;
    logic [7:0]             fifo_rd_data;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .input_clk (input_clk),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (fifo_pop),
        .rd_data   (fifo_rd_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    // Bring the transmitter's busy flag into this clock domain.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tx_busy};
        end
    end

    assign tx_busy_s = sync_q[SYNC_STAGES-1];

    // Hand-off state, hold timer and registered request/data outputs.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            trans_en_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            trans_en_q <= trans_en_d;
            data_out_q <= data_out_d;
        end
    end

    // Next-state logic; busy is sampled only after the request is released, because
    // while idle the transmitter's busy simply echoes trans_en.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        trans_en_d = trans_en_q;
        data_out_d = data_out_q;
        fifo_pop   = 1'b0;

        if (flush) begin
            state_d    = IDLE;
            trans_en_d = 1'b0;
            hold_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!empty && !tx_busy_s) begin
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    fifo_pop   = 1'b1;
                    data_out_d = fifo_rd_data;
                    hold_cnt_d = HoldLast;
                    trans_en_d = 1'b1;
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (hold_cnt_q == '0) begin
                        trans_en_d = 1'b0;
                        state_d    = DRAIN;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HoldW'(1);
                    end
                end
                DRAIN: begin
                    if (!tx_busy_s) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign trans_en = trans_en_q;
    assign data_out = data_out_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with a behavioural baud-ticked transmitter and a queue-based model.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HOLD  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, trans_en, tx_busy;
    logic [4:0] count;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .SYNC_STAGES (2)
    ) dut (
        .input_clk (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .trans_en  (trans_en),
        .data_out  (data_out),
        .tx_busy   (tx_busy)
    );

    // Transmitter model: baud tick every 4 clocks, 10-tick frame, busy echoes trans_en when idle.
    logic [1:0] div;
    logic       tx_active;
    int         ticks_left;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       stall = 1'b0;

    assign tx_busy = stall | tx_active | trans_en;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            div        <= 2'd0;
            tx_active  <= 1'b0;
            ticks_left <= 0;
            rx_valid   <= 1'b0;
            rx_byte    <= 8'h00;
        end else begin
            rx_valid <= 1'b0;
            div      <= div + 2'd1;
            if (div == 2'd3) begin
                if (tx_active) begin
                    if (ticks_left == 1) tx_active <= 1'b0;
                    ticks_left <= ticks_left - 1;
                end else if (trans_en && !stall) begin
                    tx_active  <= 1'b1;
                    ticks_left <= 10;
                    rx_valid   <= 1'b1;
                    rx_byte    <= data_out;
                end
            end
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: accepted bytes, presented bytes awaiting receipt, received log.
    logic [7:0] model_q[$];
    logic [7:0] deliv_q[$];
    logic [7:0] rx_log[$];
    logic       ovf_m = 1'b0;
    logic       prev_te = 1'b0;
    int         te_run = 0;
    int         rises = 0;
    logic [7:0] held = 8'h00;

    // Per-cycle compare, sampled on the falling edge after inputs were applied at the rising edge.
    always @(negedge clk) begin
        if (reset) begin
            model_q.delete();
            deliv_q.delete();
            ovf_m   = 1'b0;
            prev_te = 1'b0;
            te_run  = 0;
        end else begin
            if (flush) begin
                model_q.delete();
                ovf_m = 1'b0;
            end else if (wr_en) begin
                if (model_q.size() == DEPTH) ovf_m = 1'b1;
                else model_q.push_back(wr_data);
            end
            if (trans_en && !prev_te) begin
                rises++;
                check("rise_while_tx_busy", tx_active, 1'b0);
                check("rise_fifo_nonempty", model_q.size() != 0, 1);
                if (model_q.size() != 0) begin
                    held = model_q.pop_front();
                    check("data_at_rise", data_out, held);
                    deliv_q.push_back(held);
                end
                te_run = 1;
            end else if (trans_en) begin
                te_run++;
                check("data_stable", data_out, held);
            end else if (prev_te) begin
                check("trans_en_len", te_run, HOLD);
            end
            prev_te = trans_en;
            if (rx_valid) begin
                check("rx_pending", deliv_q.size() != 0, 1);
                if (deliv_q.size() != 0) check("rx_byte", rx_byte, deliv_q.pop_front());
                rx_log.push_back(rx_byte);
            end
            check("count", count, model_q.size());
            check("full", full, model_q.size() == DEPTH);
            check("empty", empty, model_q.size() == 0);
            check("overflow", overflow, ovf_m);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        cycles(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int bound);
        int k = 0;
        while (rx_log.size() < n && k < bound) begin
            cycles(1);
            k++;
        end
        check("wait_rx", rx_log.size(), n);
    endtask

    task automatic wait_te(input logic val, input int bound);
        int k = 0;
        while (trans_en !== val && k < bound) begin
            cycles(1);
            k++;
        end
        check("wait_trans_en", trans_en, val);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        int r0;

        cycles(3);
        reset = 1'b0;
        cycles(2);
        check("rst_trans_en", trans_en, 0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);

        // Single byte: latency and hold length.
        push(8'hA5);
        check("lat_edge1", trans_en, 0);
        cycles(1);
        check("lat_edge2", trans_en, 0);
        cycles(1);
        check("lat_edge3", trans_en, 1);
        check("lat_data", data_out, 8'hA5);
        n = 1;
        while (trans_en && n < 20) begin
            cycles(1);
            if (trans_en) n++;
        end
        check("a5_high_len", n, 8);
        wait_rx(1, 200);
        check("a5_rx", rx_log[0], 8'hA5);
        cycles(60);

        // Burst of three.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_rx(4, 1000);
        check("burst_0", rx_log[1], 8'h01);
        check("burst_1", rx_log[2], 8'h02);
        check("burst_2", rx_log[3], 8'h03);
        cycles(60);
        check("burst_count", count, 0);

        // Fill past full with the transmitter stalled.
        stall = 1'b1;
        cycles(4);
        for (int i = 0; i < 17; i++) begin
            push(8'(i));
            if (i == 15) check("full_after_16", full, 1);
        end
        check("count_16", count, 16);
        check("overflow_set", overflow, 1);
        cycles(10);
        check("stalled_no_req", trans_en, 0);
        stall = 1'b0;
        wait_rx(20, 2000);
        for (int i = 0; i < 16; i++) begin
            check("fill_order", rx_log[4 + i], 32'(i));
        end
        cycles(60);
        check("byte_10_lost", rx_log.size(), 20);
        check("overflow_sticky", overflow, 1);

        // Asynchronous reset mid-run, between clock edges.
        push(8'hAA);
        wait_te(1'b1, 20);
        cycles(2);
        reset = 1'b1;
        #1;
        check("arst_trans_en", trans_en, 0);
        check("arst_data_out", data_out, 8'h00);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_overflow", overflow, 0);
        cycles(2);
        reset = 1'b0;
        cycles(2);

        // Reset during HOLD with four bytes queued.
        for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
        wait_te(1'b1, 20);
        cycles(2);
        check("hold_queued", count, 4);
        reset = 1'b1;
        #1;
        check("hold_arst_trans_en", trans_en, 0);
        cycles(2);
        reset = 1'b0;
        base = rx_log.size();
        r0 = rises;
        cycles(200);
        check("post_rst_no_rx", rx_log.size(), base);
        check("post_rst_no_req", rises, r0);
        check("post_rst_count", count, 0);

        // Flush during DRAIN, with a push in the flush cycle, then a fresh byte.
        base = rx_log.size();
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        wait_te(1'b1, 40);
        wait_te(1'b0, 20);
        cycles(2);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        cycles(1);
        flush   = 1'b0;
        wr_en   = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_overflow", overflow, 0);
        push(8'h3C);
        wait_rx(base + 2, 1000);
        check("inflight_byte", rx_log[base], 8'h60);
        check("after_flush_byte", rx_log[base + 1], 8'h3C);
        cycles(80);
        check("flush_no_extra", rx_log.size(), base + 2);
        check("flush_overflow_end", overflow, 0);
        check("all_presented_received", deliv_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
